// File: rtl/code_sequence_sender_if.sv
// Press-sequence bundle between the code sender and its host/detector side.
// master drives Go/Code/U; slave (the sender) drives the press lines and status.
interface code_sequence_sender_if;
  logic       Go;
  logic [7:0] Code;
  logic       U;
  logic       Start;
  logic       Red;
  logic       Green;
  logic       Blue;
  logic       Busy;
  logic       Done;
  logic       Pass;
  logic       Err;

  modport master (
    output Go, Code, U,
    input  Start, Red, Green, Blue, Busy, Done, Pass, Err
  );

  modport slave (
    input  Go, Code, U,
    output Start, Red, Green, Blue, Busy, Done, Pass, Err
  );
endinterface

// File: rtl/code_sequence_sender.sv
// Emits Start then four one-hot colour presses (GAP idle cycles after each), then waits up to
// TIMEOUT cycles for U; Start lands 1 cycle after Go, all outputs registered, Go ignored while busy.
module code_sequence_sender #(
  parameter int GAP     = 2,
  parameter int TIMEOUT = 4
) (
  input logic                   Clk,
  input logic                   Rst,
  code_sequence_sender_if.slave bus
);

  localparam logic [3:0] GAP_L     = 4'(GAP);
  localparam logic [3:0] TIMEOUT_L = 4'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_GAP,
    S_PRESS,
    S_WAITU,
    S_DONE
  } state_t;

  state_t     state;
  logic [1:0] idx;
  logic [3:0] cnt;
  logic [7:0] code_q;
  logic       start_q, red_q, green_q, blue_q;
  logic       busy_q, done_q, pass_q, err_q;
  logic       legal;
  logic [1:0] sym;

  always_comb begin
    legal = (bus.Code[1:0] != 2'b00) && (bus.Code[3:2] != 2'b00) &&
            (bus.Code[5:4] != 2'b00) && (bus.Code[7:6] != 2'b00);
    sym   = code_q[{idx, 1'b0} +: 2];
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= S_IDLE;
      idx     <= 2'd0;
      cnt     <= 4'd0;
      code_q  <= 8'd0;
      start_q <= 1'b0;
      red_q   <= 1'b0;
      green_q <= 1'b0;
      blue_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // Pulse outputs default low so every press/status strobe lasts one cycle.
      start_q <= 1'b0;
      red_q   <= 1'b0;
      green_q <= 1'b0;
      blue_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.Go) begin
            if (legal) begin
              code_q  <= bus.Code;
              start_q <= 1'b1;
              busy_q  <= 1'b1;
              state   <= S_START;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_START: begin
          cnt   <= GAP_L;
          idx   <= 2'd0;
          state <= S_GAP;
        end
        S_GAP: begin
          // Last gap cycle: the press for symbol[idx] is registered out next.
          if (cnt == 4'd1) begin
            red_q   <= (sym == 2'b01);
            green_q <= (sym == 2'b10);
            blue_q  <= (sym == 2'b11);
            state   <= S_PRESS;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_PRESS: begin
          if (idx != 2'd3) begin
            idx   <= idx + 2'd1;
            cnt   <= GAP_L;
            state <= S_GAP;
          end else begin
            cnt   <= TIMEOUT_L;
            state <= S_WAITU;
          end
        end
        S_WAITU: begin
          if (bus.U) begin
            done_q <= 1'b1;
            pass_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= S_DONE;
          end else if (cnt == 4'd1) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= S_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.Start = start_q;
  assign bus.Red   = red_q;
  assign bus.Green = green_q;
  assign bus.Blue  = blue_q;
  assign bus.Busy  = busy_q;
  assign bus.Done  = done_q;
  assign bus.Pass  = pass_q;
  assign bus.Err   = err_q;

endmodule

// File: tb/tb_code_sequence_sender.sv
// Bench for code_sequence_sender: directed scenarios plus random traffic on two instances
// (GAP=2/TIMEOUT=4 and GAP=1/TIMEOUT=1), checked against a schedule-based reference model.
module tb_code_sequence_sender;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  code_sequence_sender_if bus0 ();
  code_sequence_sender_if bus1 ();

  code_sequence_sender #(.GAP(2), .TIMEOUT(4)) dut0 (.Clk(Clk), .Rst(Rst), .bus(bus0));
  code_sequence_sender #(.GAP(1), .TIMEOUT(1)) dut1 (.Clk(Clk), .Rst(Rst), .bus(bus1));

  typedef struct packed {
    bit         active;
    bit         in_done;
    int         s;
    logic [7:0] code;
    logic       start, red, green, blue, busy, done, pass, err;
  } mdl_t;

  mdl_t m0, m1;
  int   cyc = 0;
  int   u_at = -1;
  int   n_assert = 0;
  int   n_fail = 0;
  bit   rst, go, u0, u1;
  logic [7:0] code;
  int   base;

  int st0_q[$], pr0_q[$], pc0_q[$], dn0_q[$], ps0_q[$], er0_q[$];
  int pr1_q[$], dn1_q[$], ps1_q[$];
  int busy0_seen;

  // Expected outputs of the cycle after 'c', derived from the run's start time:
  // Start at offset 0, press k at (k+1)(g+1), then t cycles of waiting for U.
  function automatic mdl_t model_next(mdl_t m, int g, int t, int c,
                                      bit r, bit gi, bit ui, logic [7:0] ci);
    mdl_t n;
    int   len, off;
    logic [7:0] sh;
    n = m;
    len = 4 * (g + 1);
    {n.start, n.red, n.green, n.blue, n.busy, n.done, n.pass, n.err} = '0;
    if (r) begin
      n.active  = 1'b0;
      n.in_done = 1'b0;
      return n;
    end
    if (!m.active) begin
      if (m.in_done) n.in_done = 1'b0;
      else if (gi) begin
        if (ci[1:0] != 0 && ci[3:2] != 0 && ci[5:4] != 0 && ci[7:6] != 0) begin
          n.active = 1'b1;
          n.s      = c + 1;
          n.code   = ci;
        end else begin
          n.err = 1'b1;
        end
      end
    end else begin
      off = c - m.s;
      if (off > len && (ui || off == len + t)) begin
        n.active  = 1'b0;
        n.in_done = 1'b1;
        n.done    = 1'b1;
        n.pass    = ui;
      end
    end
    if (n.active) begin
      off    = c + 1 - n.s;
      n.busy = 1'b1;
      if (off == 0) n.start = 1'b1;
      else if (off <= len && off % (g + 1) == 0) begin
        sh      = n.code >> (2 * (off / (g + 1) - 1));
        n.red   = (sh[1:0] == 2'b01);
        n.green = (sh[1:0] == 2'b10);
        n.blue  = (sh[1:0] == 2'b11);
      end
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rec();
    st0_q.delete(); pr0_q.delete(); pc0_q.delete(); dn0_q.delete(); ps0_q.delete();
    er0_q.delete(); pr1_q.delete(); dn1_q.delete(); ps1_q.delete();
    busy0_seen = 0;
  endtask

  task automatic tick();
    bit ue0;
    ue0 = u0 | (cyc == u_at);
    Rst = rst;
    bus0.Go = go;   bus1.Go = go;
    bus0.Code = code; bus1.Code = code;
    bus0.U = ue0;   bus1.U = u1;
    @(posedge Clk);
    m0 = model_next(m0, 2, 4, cyc, rst, go, ue0, code);
    m1 = model_next(m1, 1, 1, cyc, rst, go, u1, code);
    cyc++;
    @(negedge Clk);
    chk("i0_start", bus0.Start, m0.start); chk("i0_red",  bus0.Red,  m0.red);
    chk("i0_green", bus0.Green, m0.green); chk("i0_blue", bus0.Blue, m0.blue);
    chk("i0_busy",  bus0.Busy,  m0.busy);  chk("i0_done", bus0.Done, m0.done);
    chk("i0_pass",  bus0.Pass,  m0.pass);  chk("i0_err",  bus0.Err,  m0.err);
    chk("i1_start", bus1.Start, m1.start); chk("i1_red",  bus1.Red,  m1.red);
    chk("i1_green", bus1.Green, m1.green); chk("i1_blue", bus1.Blue, m1.blue);
    chk("i1_busy",  bus1.Busy,  m1.busy);  chk("i1_done", bus1.Done, m1.done);
    chk("i1_pass",  bus1.Pass,  m1.pass);  chk("i1_err",  bus1.Err,  m1.err);
    chk("i0_onehot", 32'($countones({bus0.Start, bus0.Red, bus0.Green, bus0.Blue}) <= 1), 1);
    chk("i1_onehot", 32'($countones({bus1.Start, bus1.Red, bus1.Green, bus1.Blue}) <= 1), 1);
    if (bus0.Start === 1'b1) st0_q.push_back(cyc);
    if (bus0.Red === 1'b1)   begin pr0_q.push_back(cyc); pc0_q.push_back(1); end
    if (bus0.Green === 1'b1) begin pr0_q.push_back(cyc); pc0_q.push_back(2); end
    if (bus0.Blue === 1'b1)  begin pr0_q.push_back(cyc); pc0_q.push_back(3); end
    if (bus0.Done === 1'b1)  begin dn0_q.push_back(cyc); ps0_q.push_back(int'(bus0.Pass)); end
    if (bus0.Err === 1'b1)   er0_q.push_back(cyc);
    if (bus0.Busy === 1'b1)  busy0_seen++;
    if ((bus1.Red | bus1.Green | bus1.Blue) === 1'b1) pr1_q.push_back(cyc);
    if (bus1.Done === 1'b1)  begin dn1_q.push_back(cyc); ps1_q.push_back(int'(bus1.Pass)); end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int exp_col[4];
    m0 = '0; m1 = '0;
    rst = 1'b1; go = 1'b0; u0 = 1'b0; u1 = 1'b0; code = 8'h00;

    // Reset state
    idle(2);
    rst = 1'b0;
    idle(2);

    // Code 6D (R,B,G,R), detector answers in cycle 14
    clear_rec();
    code = 8'h6D; base = cyc; u_at = base + 14; go = 1'b1;
    tick();
    go = 1'b0;
    idle(24);
    u_at = -1;
    exp_col = '{1, 3, 2, 1};
    chk("t1_npress", pr0_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk("t1_press_cyc", k < pr0_q.size() ? pr0_q[k] : -1, base + 4 + 3 * k);
      chk("t1_press_col", k < pc0_q.size() ? pc0_q[k] : -1, exp_col[k]);
      chk("g1_press_cyc", k < pr1_q.size() ? pr1_q[k] : -1, base + 3 + 2 * k);
    end
    chk("t1_start_cyc", st0_q.size() > 0 ? st0_q[0] : -1, base + 1);
    chk("t1_done_cyc",  dn0_q.size() > 0 ? dn0_q[0] : -1, base + 15);
    chk("t1_pass",      ps0_q.size() > 0 ? ps0_q[0] : -1, 1);
    chk("t1_busy_len",  busy0_seen, 14);
    chk("g1_done_cyc",  dn1_q.size() > 0 ? dn1_q[0] : -1, base + 11);
    chk("g1_pass",      ps1_q.size() > 0 ? ps1_q[0] : -1, 0);

    // Code 69, no unlock: timeout
    clear_rec();
    code = 8'h69; base = cyc; go = 1'b1;
    tick();
    go = 1'b0;
    idle(24);
    chk("t2_done_cyc", dn0_q.size() > 0 ? dn0_q[0] : -1, base + 18);
    chk("t2_pass",     ps0_q.size() > 0 ? ps0_q[0] : -1, 0);
    chk("t2_busy_len", busy0_seen, 17);

    // Illegal code
    clear_rec();
    code = 8'h6C; base = cyc; go = 1'b1;
    tick();
    go = 1'b0;
    idle(20);
    chk("t3_err_cyc", er0_q.size() > 0 ? er0_q[0] : -1, base + 1);
    chk("t3_nerr",    er0_q.size(), 1);
    chk("t3_npress",  pr0_q.size() + st0_q.size(), 0);
    chk("t3_busy",    busy0_seen, 0);
    chk("t3_ndone",   dn0_q.size(), 0);

    // Reset mid-sequence, then restart
    clear_rec();
    code = 8'h6D; base = cyc; go = 1'b1;
    tick();
    go = 1'b0;
    while (cyc < base + 8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    go = 1'b1;
    tick();
    go = 1'b0;
    idle(24);
    chk("t4_nstart",   st0_q.size(), 2);
    chk("t4_restart",  st0_q.size() > 1 ? st0_q[1] : -1, base + 11);
    chk("t4_press2",   pr0_q.size() > 2 ? pr0_q[2] : -1, base + 14);
    chk("t4_ndone",    dn0_q.size(), 1);

    // Go held high across runs
    clear_rec();
    code = 8'h6D; base = cyc; u_at = base + 14; go = 1'b1;
    while (cyc < base + 19) tick();
    go = 1'b0;
    u_at = -1;
    idle(24);
    chk("t5_start0", st0_q.size() > 0 ? st0_q[0] : -1, base + 1);
    chk("t5_start1", st0_q.size() > 1 ? st0_q[1] : -1, base + 17);
    chk("t5_done0",  dn0_q.size() > 0 ? dn0_q[0] : -1, base + 15);
    chk("t5_pass0",  ps0_q.size() > 0 ? ps0_q[0] : -1, 1);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        code = {2'($urandom_range(1, 3)), 2'($urandom_range(1, 3)),
                2'($urandom_range(1, 3)), 2'($urandom_range(1, 3))};
        if ($urandom_range(0, 5) == 0) code[2 * $urandom_range(0, 3) +: 2] = 2'b00;
      end
      go  = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 199) == 0);
      u0  = ($urandom_range(0, 5) == 0);
      u1  = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/code_sequence_sender.md
Name: code_sequence_sender

Overview:
- Transmit-side companion to the colour-code lock detector. On a Go request it emits a one-hot press sequence on Start/Red/Green/Blue: Start first, then four programmed colour symbols.
- Each press is a single-cycle pulse separated by idle gaps, so a detector sees no held buttons.
- After the last press it watches the detector's unlock output U for a bounded window and reports pass or fail.
- Used as the stimulus engine for lock bring-up and as an auto-unlock driver.

Parameters:
- GAP, 2, idle cycles (all press lines low) after each press; legal range 1..15.
- TIMEOUT, 4, maximum cycles spent waiting for U after the final press; legal range 1..15.

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- Go  in  1  start request; sampled only in IDLE.
- Code  in  8  four 2-bit symbols; sym0=Code[1:0] is sent first, sym3=Code[7:6] last. Encoding: 01=Red, 10=Green, 11=Blue, 00=illegal.
- U  in  1  unlock indication from the detector.
- Start  out  1  start-button pulse.
- Red  out  1  red-button pulse.
- Green  out  1  green-button pulse.
- Blue  out  1  blue-button pulse.
- Busy  out  1  high while a sequence is in progress.
- Done  out  1  one-cycle completion pulse.
- Pass  out  1  result; valid only while Done=1, otherwise 0.
- Err  out  1  one-cycle pulse when Go is rejected for an illegal code.

Behaviour:
- Clock and reset: one clock, Clk; reset is synchronous and active-high on Rst.
- Registered outputs: all outputs are registered and all reset to 0. Rst=1 at an edge forces IDLE next cycle from any state, including mid-sequence. No partial pulse follows.
- One-hot invariant: at most one of Start/Red/Green/Blue is high in any cycle, and each is high for exactly one cycle per press.
- States: IDLE, START, GAP, PRESS, WAITU, DONE. A 2-bit symbol index and a 4-bit gap/timeout counter are held.
- IDLE: all outputs 0.
  - If Go=1 and every symbol is nonzero: latch Code into an internal register, go to START.
  - If Go=1 and any symbol is 00: Err=1 next cycle, stay IDLE, Busy stays 0.
  - Code changes after acceptance have no effect.
- START: Start=1 and Busy=1 for one cycle. Load counter=GAP, index=0, go to GAP.
- GAP: press lines low, Busy=1 for GAP cycles. Then go to PRESS.
- PRESS: drive the line for symbol[index] for one cycle, Busy=1.
  - If index<3: index+1, reload counter, go to GAP.
  - If index=3: load counter=TIMEOUT, go to WAITU. There is no trailing gap.
- WAITU: Busy=1; U is sampled each cycle.
  - U=1 at an edge: go to DONE with Pass=1.
  - Counter reaches 0 after TIMEOUT cycles with no U: go to DONE with Pass=0.
  - U high before WAITU is ignored.
- DONE: one cycle with Done=1, Busy=0 and Pass per result, then IDLE. Go is ignored in DONE.
- Go handling: Go while Busy is ignored, not queued. Go held continuously re-triggers from the first IDLE cycle.
- Timing from Go sampled at edge 0: Start in cycle 1; press k (k=0..3) in cycle 1+(k+1)(GAP+1); WAITU starts in the cycle after the last press.
- Counters: no wrap needed within the legal ranges. Out-of-range values are a configuration error and have no defined behaviour.

Test Plan:
- Default params, Code=8'h6D (R,B,G,R), bench detector model → Start cycle 1; Red 4, Blue 7, Green 10, Red 13; U high cycle 14; Done=1, Pass=1 cycle 15. Busy high cycles 1-14.
- Code=8'h69 (R,G,G,R), detector rejects → presses at 4/7/10/13, no U; WAITU cycles 14-17; Done=1, Pass=0 cycle 18.
- Code=8'h6C (sym0=00), Go pulse → Err=1 cycle 1; no press line ever high; Busy=0; Done never asserted.
- Legal run, Rst=1 at edge ending cycle 8 → cycle 9 all outputs 0, no further presses. Go in cycle 10 → Start in cycle 11 with the full sequence.
- Go held high across runs with Code=8'h6D → second Start in cycle 17 (IDLE in cycle 16). Go pulses during cycles 2-14 are ignored.
- GAP=1, TIMEOUT=1, U forced 0 → presses at 3/5/7/9; Done=1, Pass=0 cycle 11. One-hot assertion holds every cycle.
